pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Next-address controller for the 8-bit core's program counter. Each cycle it takes the decoded control-flow class, condition flags, absolute target and relative offset, and selects the next fetch address. It also owns the hardware return-address stack and interrupt entry. It drives the instruction address bus directly and emits Sel_PC and Flush to the fetch/decode stage.

Parameters:
AW, 8, address width (PC, Target, Offset, stack entries)
STACK_DEPTH, 4, return-stack entries (power of 2, 2..8)
RESET_VECTOR, 8'h00, PC value after reset
IRQ_VECTOR, 8'h04, interrupt entry address

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-low
Stall  in  1  freeze all state this cycle
Op_Valid  in  1  Op_Class/Cond/Target/Offset valid this cycle
Op_Class  in  3  000 seq, 001 jump, 010 branch, 011 call, 100 ret, 101 skip, 110 reti, 111 reserved (acts as seq)
Cond  in  2  00 Z, 01 C, 10 N, 11 always
Ban_PC  in  3  flags {N,C,Z}
Target  in  AW  absolute destination (jump/call)
Offset  in  AW  two's-complement displacement (branch)
Irq  in  1  level interrupt request
PC  out  AW  current fetch address (instruction address bus)
PC_save  out  AW  PC+1 mod 2^AW, combinational
Sel_PC  out  2  source of last PC update: 00 inc, 01 absolute/vector, 10 relative, 11 stack
Flush  out  1  discard instruction fetched this cycle
Irq_Ack  out  1  one-cycle pulse on interrupt entry
Stack_Depth  out  log2(STACK_DEPTH)+1  entries in use
Stack_Err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (Reset=0 at edge), overrides everything: PC=RESET_VECTOR, state RUN, stack empty, Stack_Depth=0, Stack_Err=0, Irq_En=1, Sel_PC=00, Flush=0, Irq_Ack=0.
- States: RUN, FLUSH. FLUSH lasts exactly one cycle, then RUN. In FLUSH: Flush=1, PC holds, ops ignored, Irq not sampled.
- Stall=1 (any state): every register holds, Irq_Ack=0. A RUN/FLUSH transition also waits for Stall=0.
- RUN, Stall=0, priority: Irq, then op.
- Interrupt is taken when Irq=1, Irq_En=1 and the stack is not full:
  - push PC (current instruction not executed)
  - PC<=IRQ_VECTOR, Sel_PC=01, Irq_En<=0, Irq_Ack=1, go FLUSH
- Interrupt with a full stack: not taken, no error; the current op executes.
- Op_Valid=0, or the op is seq/reserved: PC<=PC+1, Sel_PC=00.
- cond_true = flag selected by Cond; Cond=11 is always true.
- jump: PC<=Target, Sel=01, go FLUSH.
- branch:
  - taken: PC<=PC+Offset mod 2^AW, Sel=10, go FLUSH
  - not taken: PC+1, Sel=00, stay RUN
- call, stack not full: push PC+1, PC<=Target, Sel=01, FLUSH. Stack full: Stack_Err<=1, no push, PC<=PC+1.
- ret, stack not empty: pop, PC<=popped value, Sel=11, FLUSH. Stack empty: Stack_Err<=1, PC<=PC+1.
- reti: same as ret, plus Irq_En<=1 on a successful pop only.
- skip: PC<=PC+2 if cond_true, else PC+1. Sel=00, no flush.
- Arithmetic: all PC arithmetic is modulo 2^AW, so 8'hFF+1=8'h00. Offset is sign-interpreted, so 8'hFE means -2.
- Stack: LIFO, push/pop one per cycle max. Stack_Depth updates the same edge as the PC. Stack_Err clears only on reset.
- Sel_PC and Irq_Ack are registered; they reflect the update made on the previous edge. Flush=1 iff state==FLUSH.

Test Plan:
- Reset then 5 cycles of seq with Stall=0: PC 00,01,02,03,04,05, Sel_PC=00, Flush=0; Reset low mid-run with PC=0x37 gives PC=00 on next edge.
- PC=0x10, branch Cond=00 with Z=1, Offset=8'hFC: PC=0x0C, Sel=10, Flush=1 for one cycle, PC holds 0x0C; repeat with Z=0: PC=0x11, no flush.
- From PC=0x20: call Target=0x80, then ret at 0x85: PC=0x80 with depth 1 and Sel=01, then PC=0x21 with depth 0 and Sel=11.
- Five nested calls with STACK_DEPTH=4: 5th call sets Stack_Err=1, depth stays 4, PC advances by 1; then ret with an empty stack keeps Stack_Err=1.
- Irq=1 at PC=0x30 with a jump op present: jump ignored, PC=0x04, Irq_Ack pulse, depth+1; second Irq ignored until reti, which returns to 0x30 with Irq_En=1.
- Stall=1 held for 3 cycles during a taken branch and during FLUSH: PC, state and stack unchanged; the branch executes on the first Stall=0 cycle. PC=0xFF seq gives 0x00.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-address controller for the 8-bit core: selects the next fetch address,
// owns the hardware return-address stack and handles interrupt entry.
module pc_sequencer #(
  parameter int            AW           = 8,
  parameter int            STACK_DEPTH  = 4,
  parameter logic [AW-1:0] RESET_VECTOR = '0,
  parameter logic [AW-1:0] IRQ_VECTOR   = AW'(4)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Stall,
  input  logic                         Op_Valid,
  input  logic [2:0]                   Op_Class,
  input  logic [1:0]                   Cond,
  input  logic [2:0]                   Ban_PC,
  input  logic [AW-1:0]                Target,
  input  logic [AW-1:0]                Offset,
  input  logic                         Irq,
  output logic [AW-1:0]                PC,
  output logic [AW-1:0]                PC_save,
  output logic [1:0]                   Sel_PC,
  output logic                         Flush,
  output logic                         Irq_Ack,
  output logic [$clog2(STACK_DEPTH):0] Stack_Depth,
  output logic                         Stack_Err
);

  localparam int IW = $clog2(STACK_DEPTH);
  localparam int SW = IW + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  typedef enum logic [2:0] {
    OP_SEQ    = 3'b000,
    OP_JUMP   = 3'b001,
    OP_BRANCH = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100,
    OP_SKIP   = 3'b101,
    OP_RETI   = 3'b110,
    OP_RSVD   = 3'b111
  } op_t;

  localparam logic [1:0] SEL_INC   = 2'b00;
  localparam logic [1:0] SEL_ABS   = 2'b01;
  localparam logic [1:0] SEL_REL   = 2'b10;
  localparam logic [1:0] SEL_STACK = 2'b11;

  state_t          state, state_next;
  logic [AW-1:0]   pc_q, pc_next;
  logic [1:0]      sel_q, sel_next;
  logic            ack_q, ack_next;
  logic            irq_en_q, irq_en_next;
  logic            err_q, err_next;
  logic [SW-1:0]   depth_q, depth_next;
  logic [SW-1:0]   depth_dec;
  logic [AW-1:0]   stack_mem [STACK_DEPTH];
  logic [AW-1:0]   stack_top;
  logic            stack_full, stack_empty;
  logic            push_en;
  logic [AW-1:0]   push_data;
  logic            cond_true;
  logic            irq_take;
  op_t             op;
  logic [AW-1:0]   pc_inc;

  assign pc_inc      = pc_q + AW'(1);
  assign depth_dec   = depth_q - SW'(1);
  assign stack_full  = (depth_q == SW'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);
  assign stack_top   = stack_mem[depth_dec[IW-1:0]];
  assign irq_take    = Irq && irq_en_q && !stack_full;
  assign op          = Op_Valid ? op_t'(Op_Class) : OP_SEQ;

  // Ban_PC is packed {N,C,Z}; Cond=11 is the unconditional case
  always_comb begin
    cond_true = 1'b1;
    case (Cond)
      2'b00:   cond_true = Ban_PC[0];
      2'b01:   cond_true = Ban_PC[1];
      2'b10:   cond_true = Ban_PC[2];
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc_q;
    sel_next    = sel_q;
    ack_next    = 1'b0;
    irq_en_next = irq_en_q;
    err_next    = err_q;
    depth_next  = depth_q;
    push_en     = 1'b0;
    push_data   = '0;

    if (!Stall) begin
      case (state)
        FLUSH: state_next = RUN;
        RUN: begin
          // Interrupt pre-empts the op; the interrupted instruction is re-fetched on reti
          if (irq_take) begin
            push_en     = 1'b1;
            push_data   = pc_q;
            depth_next  = depth_q + SW'(1);
            pc_next     = IRQ_VECTOR;
            sel_next    = SEL_ABS;
            irq_en_next = 1'b0;
            ack_next    = 1'b1;
            state_next  = FLUSH;
          end else begin
            pc_next  = pc_inc;
            sel_next = SEL_INC;
            case (op)
              OP_JUMP: begin
                pc_next    = Target;
                sel_next   = SEL_ABS;
                state_next = FLUSH;
              end
              OP_BRANCH: begin
                if (cond_true) begin
                  pc_next    = pc_q + Offset;
                  sel_next   = SEL_REL;
                  state_next = FLUSH;
                end
              end
              OP_CALL: begin
                if (stack_full) begin
                  err_next = 1'b1;
                end else begin
                  push_en    = 1'b1;
                  push_data  = pc_inc;
                  depth_next = depth_q + SW'(1);
                  pc_next    = Target;
                  sel_next   = SEL_ABS;
                  state_next = FLUSH;
                end
              end
              OP_RET, OP_RETI: begin
                if (stack_empty) begin
                  err_next = 1'b1;
                end else begin
                  depth_next = depth_dec;
                  pc_next    = stack_top;
                  sel_next   = SEL_STACK;
                  state_next = FLUSH;
                  if (op == OP_RETI) irq_en_next = 1'b1;
                end
              end
              OP_SKIP: begin
                if (cond_true) pc_next = pc_q + AW'(2);
              end
              default: ;
            endcase
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= RUN;
      pc_q     <= RESET_VECTOR;
      sel_q    <= SEL_INC;
      ack_q    <= 1'b0;
      irq_en_q <= 1'b1;
      err_q    <= 1'b0;
      depth_q  <= '0;
    end else begin
      state    <= state_next;
      pc_q     <= pc_next;
      sel_q    <= sel_next;
      ack_q    <= ack_next;
      irq_en_q <= irq_en_next;
      err_q    <= err_next;
      depth_q  <= depth_next;
    end
  end

  // Entries above the depth pointer are don't-care, so the array needs no reset
  always_ff @(posedge Clk) begin
    if (Reset && push_en) stack_mem[depth_q[IW-1:0]] <= push_data;
  end

  assign PC          = pc_q;
  assign PC_save     = pc_inc;
  assign Sel_PC      = sel_q;
  assign Flush       = (state == FLUSH);
  assign Irq_Ack     = ack_q;
  assign Stack_Depth = depth_q;
  assign Stack_Err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random checking of pc_sequencer against a queue-based
// reference model of the next-address rules.
module tb_pc_sequencer;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  localparam logic [2:0] SEQ    = 3'b000;
  localparam logic [2:0] JUMP   = 3'b001;
  localparam logic [2:0] BRANCH = 3'b010;
  localparam logic [2:0] CALL   = 3'b011;
  localparam logic [2:0] RET    = 3'b100;
  localparam logic [2:0] SKIP   = 3'b101;
  localparam logic [2:0] RETI   = 3'b110;

  logic          Clk = 1'b0;
  logic          Reset, Stall, Op_Valid, Irq;
  logic [2:0]    Op_Class, Ban_PC;
  logic [1:0]    Cond;
  logic [AW-1:0] Target, Offset;
  logic [AW-1:0] PC, PC_save;
  logic [1:0]    Sel_PC;
  logic          Flush, Irq_Ack, Stack_Err;
  logic [2:0]    Stack_Depth;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_pc;
  logic [7:0] m_stack[$];
  logic [1:0] m_sel;
  logic       m_ack, m_flush, m_err, m_irq_en;

  always #5 Clk = ~Clk;

  pc_sequencer #(.AW(AW), .STACK_DEPTH(DEPTH), .RESET_VECTOR(8'h00), .IRQ_VECTOR(8'h04)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Op_Valid(Op_Valid), .Op_Class(Op_Class),
    .Cond(Cond), .Ban_PC(Ban_PC), .Target(Target), .Offset(Offset), .Irq(Irq),
    .PC(PC), .PC_save(PC_save), .Sel_PC(Sel_PC), .Flush(Flush), .Irq_Ack(Irq_Ack),
    .Stack_Depth(Stack_Depth), .Stack_Err(Stack_Err)
  );

  task automatic expectEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one call per clock edge, using the inputs about to be sampled
  task automatic modelStep();
    logic       ct;
    logic [2:0] cls;
    bit         full;
    ct   = (Cond == 2'b11) ? 1'b1 : Ban_PC[Cond];
    cls  = Op_Valid ? Op_Class : SEQ;
    full = (m_stack.size() == DEPTH);
    if (!Reset) begin
      m_pc = 8'h00; m_stack.delete(); m_sel = 2'b00; m_ack = 0;
      m_flush = 0; m_err = 0; m_irq_en = 1;
    end else if (Stall) begin
      m_ack = 0;
    end else if (m_flush) begin
      m_flush = 0; m_ack = 0;
    end else if (Irq && m_irq_en && !full) begin
      m_stack.push_back(m_pc);
      m_pc = 8'h04; m_sel = 2'b01; m_irq_en = 0; m_ack = 1; m_flush = 1;
    end else begin
      m_ack = 0;
      case (cls)
        JUMP: begin m_pc = Target; m_sel = 2'b01; m_flush = 1; end
        BRANCH:
          if (ct) begin m_pc = m_pc + Offset; m_sel = 2'b10; m_flush = 1; end
          else begin m_pc = m_pc + 8'd1; m_sel = 2'b00; end
        CALL:
          if (!full) begin
            m_stack.push_back(m_pc + 8'd1);
            m_pc = Target; m_sel = 2'b01; m_flush = 1;
          end else begin m_err = 1; m_pc = m_pc + 8'd1; m_sel = 2'b00; end
        RET, RETI:
          if (m_stack.size() > 0) begin
            m_pc = m_stack.pop_back(); m_sel = 2'b11; m_flush = 1;
            if (cls == RETI) m_irq_en = 1;
          end else begin m_err = 1; m_pc = m_pc + 8'd1; m_sel = 2'b00; end
        SKIP: begin m_pc = m_pc + (ct ? 8'd2 : 8'd1); m_sel = 2'b00; end
        default: begin m_pc = m_pc + 8'd1; m_sel = 2'b00; end
      endcase
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] exp_save;
    exp_save = m_pc + 8'd1;
    expectEq({tag, ".PC"}, PC, m_pc);
    expectEq({tag, ".PC_save"}, PC_save, exp_save);
    expectEq({tag, ".Sel_PC"}, Sel_PC, m_sel);
    expectEq({tag, ".Flush"}, Flush, m_flush);
    expectEq({tag, ".Irq_Ack"}, Irq_Ack, m_ack);
    expectEq({tag, ".Stack_Depth"}, Stack_Depth, m_stack.size());
    expectEq({tag, ".Stack_Err"}, Stack_Err, m_err);
  endtask

  task automatic applyStimulus(input logic rst_n, input logic st, input logic ov,
                               input logic [2:0] oc, input logic [1:0] cd, input logic [2:0] fl,
                               input logic [7:0] tg, input logic [7:0] of, input logic iq);
    Reset = rst_n; Stall = st; Op_Valid = ov; Op_Class = oc; Cond = cd;
    Ban_PC = fl; Target = tg; Offset = of; Irq = iq;
    modelStep();
    @(posedge Clk);
    #1;
    checkOutput("model");
  endtask

  task automatic doOp(input logic [2:0] oc, input logic [7:0] tg, input logic [7:0] of,
                      input logic [1:0] cd, input logic [2:0] fl);
    applyStimulus(1'b1, 1'b0, 1'b1, oc, cd, fl, tg, of, 1'b0);
  endtask

  task automatic doSeq();
    doOp(SEQ, 8'h00, 8'h00, 2'b11, 3'b000);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, SEQ, 2'b11, 3'b000, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic jumpTo(input logic [7:0] tg);
    doOp(JUMP, tg, 8'h00, 2'b11, 3'b000);
    doSeq();
  endtask

  initial begin
    doReset();
    doReset();
    expectEq("reset_pc", PC, 8'h00);
    expectEq("reset_flush", Flush, 1'b0);
    expectEq("reset_depth", Stack_Depth, 3'd0);

    for (int i = 1; i <= 5; i++) begin
      doSeq();
      expectEq("seq_pc", PC, i);
      expectEq("seq_sel", Sel_PC, 2'b00);
    end

    jumpTo(8'h37);
    expectEq("pre_reset_pc", PC, 8'h37);
    doReset();
    expectEq("midrun_reset_pc", PC, 8'h00);

    jumpTo(8'h10);
    doOp(BRANCH, 8'h00, 8'hFC, 2'b00, 3'b001);
    expectEq("br_taken_pc", PC, 8'h0C);
    expectEq("br_taken_sel", Sel_PC, 2'b10);
    expectEq("br_taken_flush", Flush, 1'b1);
    doSeq();
    expectEq("br_flush_hold_pc", PC, 8'h0C);
    expectEq("br_flush_done", Flush, 1'b0);
    jumpTo(8'h10);
    doOp(BRANCH, 8'h00, 8'hFC, 2'b00, 3'b000);
    expectEq("br_not_taken_pc", PC, 8'h11);
    expectEq("br_not_taken_flush", Flush, 1'b0);

    jumpTo(8'h20);
    doOp(CALL, 8'h80, 8'h00, 2'b11, 3'b000);
    expectEq("call_pc", PC, 8'h80);
    expectEq("call_depth", Stack_Depth, 3'd1);
    expectEq("call_sel", Sel_PC, 2'b01);
    doSeq();
    for (int i = 0; i < 5; i++) doSeq();
    expectEq("before_ret_pc", PC, 8'h85);
    doOp(RET, 8'h00, 8'h00, 2'b11, 3'b000);
    expectEq("ret_pc", PC, 8'h21);
    expectEq("ret_depth", Stack_Depth, 3'd0);
    expectEq("ret_sel", Sel_PC, 2'b11);
    doSeq();

    for (int i = 0; i < 4; i++) begin
      doOp(CALL, 8'(8'h40 + 8'(i * 16)), 8'h00, 2'b11, 3'b000);
      doSeq();
    end
    expectEq("nest_depth4", Stack_Depth, 3'd4);
    doOp(CALL, 8'h90, 8'h00, 2'b11, 3'b000);
    expectEq("overflow_err", Stack_Err, 1'b1);
    expectEq("overflow_depth", Stack_Depth, 3'd4);
    expectEq("overflow_pc", PC, 8'h71);
    for (int i = 0; i < 4; i++) begin
      doOp(RET, 8'h00, 8'h00, 2'b11, 3'b000);
      doSeq();
    end
    expectEq("unwound_pc", PC, 8'h22);
    doOp(RET, 8'h00, 8'h00, 2'b11, 3'b000);
    expectEq("underflow_pc", PC, 8'h23);
    expectEq("underflow_err_sticky", Stack_Err, 1'b1);
    doReset();
    expectEq("reset_clears_err", Stack_Err, 1'b0);

    jumpTo(8'h30);
    applyStimulus(1'b1, 1'b0, 1'b1, JUMP, 2'b11, 3'b000, 8'h99, 8'h00, 1'b1);
    expectEq("irq_pc", PC, 8'h04);
    expectEq("irq_ack", Irq_Ack, 1'b1);
    expectEq("irq_depth", Stack_Depth, 3'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, SEQ, 2'b11, 3'b000, 8'h00, 8'h00, 1'b1);
    expectEq("irq_ack_pulse", Irq_Ack, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, SEQ, 2'b11, 3'b000, 8'h00, 8'h00, 1'b1);
    expectEq("irq_masked_pc", PC, 8'h05);
    doOp(RETI, 8'h00, 8'h00, 2'b11, 3'b000);
    expectEq("reti_pc", PC, 8'h30);
    doSeq();
    applyStimulus(1'b1, 1'b0, 1'b0, SEQ, 2'b11, 3'b000, 8'h00, 8'h00, 1'b1);
    expectEq("irq_reenabled_ack", Irq_Ack, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, SEQ, 2'b11, 3'b000, 8'h00, 8'h00, 1'b0);
    expectEq("stall_clears_ack", Irq_Ack, 1'b0);
    doSeq();
    doOp(RETI, 8'h00, 8'h00, 2'b11, 3'b000);
    doSeq();

    jumpTo(8'h10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, BRANCH, 2'b00, 3'b001, 8'h00, 8'hFC, 1'b0);
      expectEq("stall_branch_pc", PC, 8'h10);
    end
    doOp(BRANCH, 8'h00, 8'hFC, 2'b00, 3'b001);
    expectEq("stall_released_pc", PC, 8'h0C);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, JUMP, 2'b11, 3'b000, 8'hAA, 8'h00, 1'b1);
      expectEq("stall_in_flush", Flush, 1'b1);
    end
    doSeq();
    expectEq("flush_after_stall", Flush, 1'b0);
    doSeq();
    doOp(SKIP, 8'h00, 8'h00, 2'b01, 3'b010);
    expectEq("skip_taken_pc", PC, 8'h0F);
    doOp(SKIP, 8'h00, 8'h00, 2'b10, 3'b000);
    expectEq("skip_not_taken_pc", PC, 8'h10);

    jumpTo(8'hFF);
    expectEq("wrap_pc_save", PC_save, 8'h00);
    doSeq();
    expectEq("wrap_pc", PC, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 7) != 0), 3'($urandom), 2'($urandom), 3'($urandom),
                    8'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
